// File: rtl/refresh_tick_counter.sv
// rtl/refresh_tick_counter.sv - synchronised falling-edge divider raising refresh requests with ack handshake
//
// Purpose: samples an asynchronous count input into the sysclk domain, counts its
// falling edges modulo (period+1), and queues one refresh request per wrap in a
// saturating pending counter drained by the sequencer's ack pulses.
//
// Ports:
//   sysclk     in   system clock, all state on rising edge
//   sys_rst_n  in   synchronous active-low reset
//   cnt_in_n   in   asynchronous count input, counted on its falling edge
//   clr        in   synchronous clear of count, pending requests and overflow
//   period     in   terminal count; q wraps from period to 0
//   ack        in   sequencer accepts one request
//   q          out  current count
//   tc         out  one-cycle pulse on each wrap
//   req        out  high while pend != 0
//   pend       out  outstanding request count (saturating)
//   ovf        out  sticky: a wrap was lost because pend was saturated
module refresh_tick_counter #(
    parameter int WIDTH  = 8,
    parameter int PEND_W = 2
) (
    input  logic              sysclk,
    input  logic              sys_rst_n,
    input  logic              cnt_in_n,
    input  logic              clr,
    input  logic [WIDTH-1:0]  period,
    input  logic              ack,
    output logic [WIDTH-1:0]  q,
    output logic              tc,
    output logic              req,
    output logic [PEND_W-1:0] pend,
    output logic              ovf
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic              r_s1;
    logic              r_s2;
    logic              r_s3;
    logic [WIDTH-1:0]  r_q;
    logic              r_tc;
    logic [PEND_W-1:0] r_pend;
    logic              r_req;
    logic              r_ovf;

    logic              w_fall;
    logic              w_wrap;
    logic [PEND_W-1:0] w_pend_nxt;
    logic              w_ovf_nxt;

    // s3 high and s2 low marks the first cycle the synchronised input is seen low,
    // so a held-low input produces exactly one fall.
    assign w_fall = r_s3 & ~r_s2;

    // Using >= rather than == means lowering period below q wraps on the next fall
    // instead of letting q run up to the WIDTH limit.
    assign w_wrap = w_fall & (r_q >= period);

    always_comb begin
        w_pend_nxt = r_pend;
        w_ovf_nxt  = r_ovf;
        if (clr) begin
            w_pend_nxt = '0;
            w_ovf_nxt  = 1'b0;
        end else if (w_wrap && ack && (r_pend != '0)) begin
            // one request in, one out: net zero
            w_pend_nxt = r_pend;
        end else if (w_wrap && (r_pend == PEND_MAX)) begin
            w_ovf_nxt  = 1'b1;
        end else if (w_wrap) begin
            w_pend_nxt = r_pend + PEND_W'(1);
        end else if (ack && (r_pend != '0)) begin
            w_pend_nxt = r_pend - PEND_W'(1);
        end
    end

    always_ff @(posedge sysclk) begin
        if (!sys_rst_n) begin
            // Sync chain presets to idle-high so releasing reset never creates a fall.
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_s3   <= 1'b1;
            r_q    <= '0;
            r_tc   <= 1'b0;
            r_pend <= '0;
            r_req  <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_s1 <= cnt_in_n;
            r_s2 <= r_s1;
            r_s3 <= r_s2;

            if (clr) begin
                r_q  <= '0;
                r_tc <= 1'b0;
            end else if (w_wrap) begin
                r_q  <= '0;
                r_tc <= 1'b1;
            end else if (w_fall) begin
                r_q  <= r_q + WIDTH'(1);
                r_tc <= 1'b0;
            end else begin
                r_tc <= 1'b0;
            end

            r_pend <= w_pend_nxt;
            r_req  <= (w_pend_nxt != '0);
            r_ovf  <= w_ovf_nxt;
        end
    end

    assign q    = r_q;
    assign tc   = r_tc;
    assign req  = r_req;
    assign pend = r_pend;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_refresh_tick_counter.sv
// tb/tb_refresh_tick_counter.sv - directed self-checking bench for refresh_tick_counter
module tb_refresh_tick_counter;

    logic       sysclk = 1'b0;
    logic       sys_rst_n;
    logic       cnt_in_n;
    logic       clr;
    logic [7:0] period;
    logic       ack;
    logic [7:0] q;
    logic       tc;
    logic       req;
    logic [1:0] pend;
    logic       ovf;

    int vec  = 0;
    int miss = 0;

    refresh_tick_counter #(.WIDTH(8), .PEND_W(2)) dut (
        .sysclk    (sysclk),
        .sys_rst_n (sys_rst_n),
        .cnt_in_n  (cnt_in_n),
        .clr       (clr),
        .period    (period),
        .ack       (ack),
        .q         (q),
        .tc        (tc),
        .req       (req),
        .pend      (pend),
        .ovf       (ovf)
    );

    always #5 sysclk = ~sysclk;

    // Advance one rising edge and settle; inputs are driven and outputs sampled here.
    task automatic cyc();
        @(posedge sysclk);
        #1;
    endtask

    // One low pulse of 4 cycles then 4 high cycles. Input goes low just after an edge,
    // so the first sampling edge is the next one; q is expected to move on the third.
    // ack_on/clr_on are asserted only for the edge on which the fall is acted upon.
    task automatic fall_pulse(input logic ack_on, input logic clr_on,
                              output logic [7:0] q_before, output logic [7:0] q_after,
                              output logic tc_after);
        cnt_in_n = 1'b0;
        cyc();
        cyc();
        q_before = q;
        ack = ack_on;
        clr = clr_on;
        cyc();
        ack = 1'b0;
        clr = 1'b0;
        q_after  = q;
        tc_after = tc;
        cyc();
        cnt_in_n = 1'b1;
        repeat (4) cyc();
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        clr = 1'b0; ack = 1'b0; period = 8'd3;
        cnt_in_n = 1'b0;
        cyc();
        cnt_in_n = 1'b1;
        cyc();
        vec++;
        if (q !== 8'd0 || tc !== 1'b0 || req !== 1'b0 || pend !== 2'd0 || ovf !== 1'b0) begin
            miss++;
            $display("FAIL reset_state got q=%0d tc=%b req=%b pend=%0d ovf=%b want all zero", q, tc, req, pend, ovf);
        end
        sys_rst_n = 1'b1;
        repeat (5) cyc();
        vec++;
        if (q !== 8'd0 || tc !== 1'b0 || pend !== 2'd0) begin
            miss++;
            $display("FAIL reset_release_no_count got q=%0d tc=%b pend=%0d want 0 0 0", q, tc, pend);
        end
    endtask

    task automatic test_count_wrap();
        logic [7:0] qb, qa;
        logic       t;
        logic [7:0] exp_q  [4] = '{8'd1, 8'd2, 8'd3, 8'd0};
        logic [7:0] exp_qb [4] = '{8'd0, 8'd1, 8'd2, 8'd3};
        logic       exp_tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        period = 8'd3;
        for (int i = 0; i < 4; i++) begin
            fall_pulse(1'b0, 1'b0, qb, qa, t);
            vec++;
            if (qb !== exp_qb[i]) begin
                miss++;
                $display("FAIL count_latency[%0d] got q=%0d before 3rd edge want %0d", i, qb, exp_qb[i]);
            end
            vec++;
            if (qa !== exp_q[i] || t !== exp_tc[i]) begin
                miss++;
                $display("FAIL count_seq[%0d] got q=%0d tc=%b want q=%0d tc=%b", i, qa, t, exp_q[i], exp_tc[i]);
            end
        end
        vec++;
        if (pend !== 2'd1 || req !== 1'b1 || tc !== 1'b0) begin
            miss++;
            $display("FAIL count_pend got pend=%0d req=%b tc=%b want 1 1 0", pend, req, tc);
        end
    endtask

    task automatic test_ack();
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        vec++;
        if (pend !== 2'd0 || req !== 1'b0) begin
            miss++;
            $display("FAIL ack_drain got pend=%0d req=%b want 0 0", pend, req);
        end
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        vec++;
        if (pend !== 2'd0 || req !== 1'b0 || ovf !== 1'b0) begin
            miss++;
            $display("FAIL ack_underflow got pend=%0d req=%b ovf=%b want 0 0 0", pend, req, ovf);
        end
    endtask

    task automatic test_saturate();
        logic [7:0] qb, qa;
        logic       t;
        logic [1:0] exp_p [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic       exp_o [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        period = 8'd0;
        for (int i = 0; i < 5; i++) begin
            fall_pulse(1'b0, 1'b0, qb, qa, t);
            vec++;
            if (pend !== exp_p[i] || ovf !== exp_o[i] || qa !== 8'd0 || t !== 1'b1) begin
                miss++;
                $display("FAIL saturate[%0d] got pend=%0d ovf=%b q=%0d tc=%b want pend=%0d ovf=%b q=0 tc=1",
                         i, pend, ovf, qa, t, exp_p[i], exp_o[i]);
            end
        end
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        vec++;
        if (pend !== 2'd0 || ovf !== 1'b0 || q !== 8'd0 || req !== 1'b0) begin
            miss++;
            $display("FAIL saturate_clr got pend=%0d ovf=%b q=%0d req=%b want 0 0 0 0", pend, ovf, q, req);
        end
    endtask

    task automatic test_coincident();
        logic [7:0] qb, qa;
        logic       t;
        period = 8'd0;
        fall_pulse(1'b0, 1'b0, qb, qa, t);
        fall_pulse(1'b0, 1'b0, qb, qa, t);
        vec++;
        if (pend !== 2'd2) begin
            miss++;
            $display("FAIL coincide_setup got pend=%0d want 2", pend);
        end
        fall_pulse(1'b1, 1'b0, qb, qa, t);
        vec++;
        if (pend !== 2'd2 || t !== 1'b1 || req !== 1'b1) begin
            miss++;
            $display("FAIL wrap_ack got pend=%0d tc=%b req=%b want 2 1 1", pend, t, req);
        end
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        period = 8'd5;
        fall_pulse(1'b0, 1'b0, qb, qa, t);
        fall_pulse(1'b0, 1'b0, qb, qa, t);
        vec++;
        if (qa !== 8'd2) begin
            miss++;
            $display("FAIL clr_setup got q=%0d want 2", qa);
        end
        fall_pulse(1'b0, 1'b1, qb, qa, t);
        vec++;
        if (qa !== 8'd0 || t !== 1'b0 || pend !== 2'd0) begin
            miss++;
            $display("FAIL clr_vs_fall got q=%0d tc=%b pend=%0d want 0 0 0", qa, t, pend);
        end
        // sync chain is untouched by clr, so counting resumes normally
        fall_pulse(1'b0, 1'b0, qb, qa, t);
        vec++;
        if (qa !== 8'd1) begin
            miss++;
            $display("FAIL clr_resume got q=%0d want 1", qa);
        end
    endtask

    task automatic test_period_drop();
        logic [7:0] qb, qa;
        logic       t;
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        period = 8'd9;
        for (int i = 0; i < 6; i++) fall_pulse(1'b0, 1'b0, qb, qa, t);
        vec++;
        if (qa !== 8'd6 || pend !== 2'd0) begin
            miss++;
            $display("FAIL period_setup got q=%0d pend=%0d want 6 0", qa, pend);
        end
        period = 8'd4;
        fall_pulse(1'b0, 1'b0, qb, qa, t);
        vec++;
        if (qa !== 8'd0 || t !== 1'b1 || pend !== 2'd1 || req !== 1'b1) begin
            miss++;
            $display("FAIL period_drop got q=%0d tc=%b pend=%0d req=%b want 0 1 1 1", qa, t, pend, req);
        end
    endtask

    task automatic test_midreset();
        period = 8'd7;
        cnt_in_n = 1'b0;
        cyc();
        sys_rst_n = 1'b0;
        cyc();
        cnt_in_n = 1'b1;
        sys_rst_n = 1'b1;
        vec++;
        if (q !== 8'd0 || pend !== 2'd0 || req !== 1'b0 || ovf !== 1'b0) begin
            miss++;
            $display("FAIL midreset got q=%0d pend=%0d req=%b ovf=%b want 0 0 0 0", q, pend, req, ovf);
        end
        repeat (4) cyc();
        vec++;
        if (q !== 8'd0 || tc !== 1'b0) begin
            miss++;
            $display("FAIL midreset_inflight got q=%0d tc=%b want 0 0", q, tc);
        end
    endtask

    initial begin
        test_reset();
        test_count_wrap();
        test_ack();
        test_saturate();
        test_coincident();
        test_period_drop();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
